// File: rtl/multicycle_core_pkg.sv
// Shared types for the multicycle 9-bit core: opcodes, FSM states, instruction field positions.
package core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ADDI = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5,
        OP_BEQZ = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int IW     = 9;
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RA_MSB = 5;
    localparam int RA_LSB = 3;
    localparam int RB_MSB = 2;
    localparam int RB_LSB = 0;

endpackage

// File: rtl/multicycle_core_if.sv
// Data-memory req/ack port of the multicycle core; core is master, DataRAM wrapper is slave.
interface multicycle_core_if #(
    parameter int DW = 8,
    parameter int AW = 8
) ();
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    input  dmem_rdata, dmem_ack);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    output dmem_rdata, dmem_ack);
endinterface

// File: rtl/multicycle_core_alu.sv
// Combinational ALU; cout is carry-out for ADD and borrow-out for SUB, other ops pass operand a.
module core_alu
    import core_pkg::*;
#(
    parameter int DW = 8
) (
    input  op_t           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          cin_i,
    output logic [DW-1:0] res_o,
    output logic          cout_o,
    output logic          zero_o
);
    always_comb begin
        res_o  = a_i;
        cout_o = 1'b0;
        case (op_i)
            OP_ADD:  {cout_o, res_o} = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, cin_i};
            OP_SUB:  {cout_o, res_o} = {1'b0, a_i} - {1'b0, b_i} - {{DW{1'b0}}, cin_i};
            OP_AND:  res_o = a_i & b_i;
            OP_ADDI: res_o = a_i + b_i;
            default: ;
        endcase
        zero_o = (res_o == '0);
    end
endmodule

// File: rtl/multicycle_core.sv
// Multicycle fetch/execute/memory core with req/ack data port.
// Optional macro CARRY_CHAIN_EN adds a carry flag chaining ADD/SUB.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 8,
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic               CLK,
    input  logic               start,
    output logic [PW-1:0]      imem_addr,
    input  logic [IW-1:0]      imem_data,
    multicycle_core_if.master  dmem,
    output logic               halt,
    output logic [CW-1:0]      inst_count
);
    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] regs_q [8];
    logic [DW-1:0] regs_d [8];
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    op_t           op;
    logic [2:0]    ra, rb;
    logic [DW-1:0] rd_a, rd_b, imm_d, alu_b, alu_res;
    logic [PW-1:0] imm_p;
    logic          alu_cin, alu_cout, alu_zero;

    assign op    = op_t'(ir_q[OP_MSB:OP_LSB]);
    assign ra    = ir_q[RA_MSB:RA_LSB];
    assign rb    = ir_q[RB_MSB:RB_LSB];
    assign rd_a  = regs_q[ra];
    assign rd_b  = regs_q[rb];
    assign imm_d = {{(DW-3){ir_q[2]}}, ir_q[2:0]};
    assign imm_p = {{(PW-3){ir_q[2]}}, ir_q[2:0]};
    assign alu_b = (op == OP_ADDI) ? imm_d : rd_b;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef CARRY_CHAIN_EN
    logic carry_q, carry_d;
    assign alu_cin = carry_q;
`else
    logic unused_cout;
    assign alu_cin     = 1'b0;
    assign unused_cout = alu_cout;
`endif

    // BEQZ falls through the ALU as a pass of R[ra], so zero_o is the branch condition
    core_alu #(.DW(DW)) u_alu (
        .op_i   (op),
        .a_i    (rd_a),
        .b_i    (alu_b),
        .cin_i  (alu_cin),
        .res_o  (alu_res),
        .cout_o (alu_cout),
        .zero_o (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        cnt_d   = cnt_q;
`ifdef CARRY_CHAIN_EN
        carry_d = carry_q;
`endif
        case (state_q)
            S_FETCH: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_ADDI: begin
                        regs_d[ra] = alu_res;
                        pc_d       = pc_q + 1'b1;
                        cnt_d      = cnt_inc;
                        state_d    = S_FETCH;
`ifdef CARRY_CHAIN_EN
                        carry_d    = (op == OP_ADD || op == OP_SUB) ? alu_cout : 1'b0;
`endif
                    end
                    OP_BEQZ: begin
                        pc_d    = alu_zero ? pc_q + imm_p : pc_q + 1'b1;
                        cnt_d   = cnt_inc;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default: begin
                        cnt_d   = cnt_inc;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem.dmem_ack) begin
                    if (op == OP_LW) regs_d[ra] = dmem.dmem_rdata;
                    pc_d    = pc_q + 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            regs_q  <= '{default: '0};
            cnt_q   <= '0;
`ifdef CARRY_CHAIN_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
            cnt_q   <= cnt_d;
`ifdef CARRY_CHAIN_EN
            carry_q <= carry_d;
`endif
        end
    end

    // Request is a decode of the registered state; operands come from IR/regs, which hold during S_MEM
    assign dmem.dmem_req   = (state_q == S_MEM);
    assign dmem.dmem_we    = (op == OP_SW);
    assign dmem.dmem_addr  = rd_a[AW-1:0];
    assign dmem.dmem_wdata = rd_b;

    assign imem_addr  = pc_q;
    assign halt       = (state_q == S_HALT);
    assign inst_count = cnt_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: program table plus hand sequences for branch wrap, abort, saturation.
module tb_multicycle_core;
    localparam logic [8:0] HALT_W = 9'h1C0;
    localparam int NV = 6;

    logic       CLK = 1'b0;
    logic       start = 1'b1;
    logic [7:0] imem_addr;
    logic [8:0] imem_data;
    logic       halt;
    logic [3:0] inst_count;

    logic [8:0] rom [256];
    logic [7:0] mem [256];
    int         ack_dly = 0;
    bit         ack_force = 1'b0;
    int         wait_cnt = 0;

    int         req_cyc = 0;
    bit         addr_bad = 1'b0, prev_req = 1'b0, wr_seen = 1'b0;
    logic [7:0] prev_addr = '0, wr_addr = '0, wr_data = '0;

    int nvec = 0, nerr = 0;

    multicycle_core_if #(.DW(8), .AW(8)) bus ();

    multicycle_core #(.DW(8), .PW(8), .AW(8), .CW(4)) dut (
        .CLK        (CLK),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem       (bus.master),
        .halt       (halt),
        .inst_count (inst_count)
    );

    always #5 CLK = ~CLK;

    assign imem_data       = rom[imem_addr];
    assign bus.dmem_rdata  = mem[bus.dmem_addr];
    assign bus.dmem_ack    = (bus.dmem_req && wait_cnt >= ack_dly) || ack_force;

    always @(posedge CLK) begin
        if (start || !bus.dmem_req || bus.dmem_ack) wait_cnt <= 0;
        else                                        wait_cnt <= wait_cnt + 1;
    end

    always @(negedge CLK) begin
        if (start) begin
            req_cyc  <= 0;
            addr_bad <= 1'b0;
            wr_seen  <= 1'b0;
        end else if (bus.dmem_req) begin
            req_cyc <= req_cyc + 1;
            if (prev_req && bus.dmem_addr != prev_addr) addr_bad <= 1'b1;
            if (bus.dmem_we) begin
                wr_seen <= 1'b1;
                wr_addr <= bus.dmem_addr;
                wr_data <= bus.dmem_wdata;
            end
        end
        prev_req  <= bus.dmem_req && !start;
        prev_addr <= bus.dmem_addr;
    end

    typedef struct {
        logic [8:0] prog [16];
        int         ack_dly;
        int         ra, rb;
        logic [7:0] ea, eb;
        int         ecnt, ecyc, ereq;
    } vec_t;
    vec_t tv [NV];

    function automatic logic [8:0] enc(input int op, input int ra, input int rb);
        logic [2:0] o, a, b;
        o = op[2:0]; a = ra[2:0]; b = rb[2:0];
        return {o, a, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge CLK);
        start = 1'b1;
        repeat (n) @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (!halt && cyc < 300) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = HALT_W;
    endtask

    initial begin
        int cyc;

        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
        mem[8'h00] = 8'h77;
        mem[8'h01] = 8'h20;
        mem[8'h02] = 8'h5C;
        mem[8'h10] = 8'hA5;

        for (int i = 0; i < NV; i++) begin
            for (int a = 0; a < 16; a++) tv[i].prog[a] = HALT_W;
            tv[i].ack_dly = 0;
            tv[i].ereq    = 0;
        end
        // basic ALU/ADDI
        tv[0].prog[0] = enc(3,1,3); tv[0].prog[1] = enc(3,2,6); tv[0].prog[2] = enc(0,1,2);
        tv[0].ra = 1; tv[0].ea = 8'h01; tv[0].rb = 2; tv[0].eb = 8'hFE;
        tv[0].ecnt = 4; tv[0].ecyc = 8;
        // SUB wraps, AND
        tv[1].prog[0] = enc(3,1,3); tv[1].prog[1] = enc(3,2,7); tv[1].prog[2] = enc(1,1,2);
        tv[1].prog[3] = enc(2,2,1);
        tv[1].ra = 1; tv[1].ea = 8'h04; tv[1].rb = 2; tv[1].eb = 8'h04;
        tv[1].ecnt = 5; tv[1].ecyc = 10;
        // BEQZ not taken then taken, skipping PC 4
        tv[2].prog[0] = enc(3,1,1); tv[2].prog[1] = enc(6,1,2); tv[2].prog[2] = enc(3,2,3);
        tv[2].prog[3] = enc(6,0,2); tv[2].prog[4] = enc(3,2,1);
        tv[2].ra = 1; tv[2].ea = 8'h01; tv[2].rb = 2; tv[2].eb = 8'h03;
        tv[2].ecnt = 5; tv[2].ecyc = 10;
        // carry chain: r1=0xFF + 1, then ADD r3,r0 picks up the carry only when enabled
        tv[3].prog[0] = enc(3,1,7); tv[3].prog[1] = enc(3,2,1); tv[3].prog[2] = enc(0,1,2);
        tv[3].prog[3] = enc(0,3,0);
        tv[3].ra = 1; tv[3].ea = 8'h00; tv[3].rb = 3;
`ifdef CARRY_CHAIN_EN
        tv[3].eb = 8'h01;
`else
        tv[3].eb = 8'h00;
`endif
        tv[3].ecnt = 5; tv[3].ecyc = 10;
        // LW r3 from 0x10 with ack 4 cycles late
        tv[4].prog[0] = enc(3,3,2); tv[4].prog[1] = enc(0,3,3); tv[4].prog[2] = enc(0,3,3);
        tv[4].prog[3] = enc(0,3,3); tv[4].prog[4] = enc(4,3,0);
        tv[4].ack_dly = 4; tv[4].ereq = 5;
        tv[4].ra = 3; tv[4].ea = 8'hA5; tv[4].rb = 0; tv[4].eb = 8'h00;
        tv[4].ecnt = 6; tv[4].ecyc = 17;
        // load r4=0x20, r5=0x5C, then SW r4,r5 with immediate ack
        tv[5].prog[0] = enc(3,4,1); tv[5].prog[1] = enc(4,4,0); tv[5].prog[2] = enc(3,5,2);
        tv[5].prog[3] = enc(4,5,0); tv[5].prog[4] = enc(5,4,5);
        tv[5].ereq = 3;
        tv[5].ra = 4; tv[5].ea = 8'h20; tv[5].rb = 5; tv[5].eb = 8'h5C;
        tv[5].ecnt = 6; tv[5].ecyc = 15;

        // reset state while start held
        clear_rom();
        repeat (2) @(negedge CLK);
        chk("rst_pc", 32'(imem_addr), 32'h0);
        chk("rst_cnt", 32'(inst_count), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_req", 32'(bus.dmem_req), 32'h0);

        for (int i = 0; i < NV; i++) begin
            clear_rom();
            for (int a = 0; a < 16; a++) rom[a] = tv[i].prog[a];
            ack_dly = tv[i].ack_dly;
            do_start(2);
            run_halt(cyc);
            @(negedge CLK);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tv[i].ecyc));
            chk($sformatf("v%0d_count", i), 32'(inst_count), 32'(tv[i].ecnt));
            chk($sformatf("v%0d_r%0d", i, tv[i].ra), 32'(dut.regs_q[tv[i].ra]), 32'(tv[i].ea));
            chk($sformatf("v%0d_r%0d", i, tv[i].rb), 32'(dut.regs_q[tv[i].rb]), 32'(tv[i].eb));
            chk($sformatf("v%0d_req_cycles", i), 32'(req_cyc), 32'(tv[i].ereq));
            chk($sformatf("v%0d_addr_stable", i), 32'(addr_bad), 32'h0);
        end
        // last vector was the store
        chk("sw_seen", 32'(wr_seen), 32'h1);
        chk("sw_addr", 32'(wr_addr), 32'h20);
        chk("sw_wdata", 32'(wr_data), 32'h5C);
        ack_dly = 0;

        // BEQZ r0,-1 at PC 0 wraps to 0xFF
        clear_rom();
        rom[0] = enc(6,0,7);
        do_start(2);
        repeat (2) @(posedge CLK);
        #1;
        chk("beqz_wrap_pc", 32'(imem_addr), 32'hFF);
        run_halt(cyc);
        chk("beqz_wrap_cnt", 32'(inst_count), 32'h2);
        chk("beqz_wrap_halt", 32'(halt), 32'h1);

        // start during an S_MEM wait aborts the load
        clear_rom();
        rom[0] = enc(4,3,0);
        ack_dly = 20;
        do_start(2);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("abort_req_before", 32'(bus.dmem_req), 32'h1);
        start = 1'b1;
        ack_force = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_req", 32'(bus.dmem_req), 32'h0);
        chk("abort_pc", 32'(imem_addr), 32'h0);
        chk("abort_cnt", 32'(inst_count), 32'h0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("abort_r3", 32'(dut.regs_q[3]), 32'h0);
        @(negedge CLK);
        ack_force = 1'b0;
        ack_dly = 0;
        start = 1'b0;
        run_halt(cyc);
        chk("abort_rerun_cycles", 32'(cyc), 32'd5);
        chk("abort_rerun_r3", 32'(dut.regs_q[3]), 32'h77);

        // tight BEQZ loop saturates the 4-bit counter
        clear_rom();
        rom[0] = enc(6,0,0);
        do_start(2);
        repeat (40) @(posedge CLK);
        #1;
        chk("sat_cnt", 32'(inst_count), 32'hF);
        chk("sat_pc", 32'(imem_addr), 32'h0);
        chk("sat_halt", 32'(halt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
